// File: rtl/tx_write_requester_64_if.sv
// rtl/tx_write_requester_64_if.sv - SG element and write-request bus between requester and TX engine
interface tx_write_requester_64_if;
  logic        SG_ELEM_RDY;
  logic [63:0] SG_ELEM_ADDR;
  logic [31:0] SG_ELEM_LEN;
  logic        SG_ELEM_REN;
  logic        WR_REQ;
  logic        WR_REQ_ACK;
  logic [63:0] WR_ADDR;
  logic [9:0]  WR_LEN;
  logic        WR_LAST;
  logic        WR_SENT;

  // requester side: pops SG elements, issues write requests
  modport master (
    input  SG_ELEM_RDY, SG_ELEM_ADDR, SG_ELEM_LEN, WR_REQ_ACK, WR_SENT,
    output SG_ELEM_REN, WR_REQ, WR_ADDR, WR_LEN, WR_LAST
  );

  // SG reader / TX engine side
  modport slave (
    output SG_ELEM_RDY, SG_ELEM_ADDR, SG_ELEM_LEN, WR_REQ_ACK, WR_SENT,
    input  SG_ELEM_REN, WR_REQ, WR_ADDR, WR_LEN, WR_LAST
  );
endinterface

// File: rtl/tx_write_requester_64.sv
// rtl/tx_write_requester_64.sv - splits a TX transaction into max-payload, 4KB-safe memory-write requests
module tx_write_requester_64 #(
  parameter int C_DATA_WIDTH     = 64,
  parameter int C_MAX_PAYLOAD_DW = 256
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [2:0]                CONFIG_MAX_PAYLOAD_SIZE,
  input  logic                      TXN,
  input  logic [31:0]               TXN_LEN,
  output logic                      TXN_ACK,
  input  logic                      ABORT,
  output logic                      DONE,
  output logic [31:0]               DONE_LEN,
  tx_write_requester_64_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SG, S_CALC, S_REQ, S_WAIT_SENT, S_DONE
  } state_t;

  localparam logic [10:0] MP_CLAMP = 11'(C_MAX_PAYLOAD_DW);

  state_t      state_q, state_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] sent_q, sent_d;
  logic [63:0] elem_addr_q, elem_addr_d;
  logic [29:0] elem_remain_q, elem_remain_d;
  logic [10:0] req_len_q, req_len_d;
  logic        abort_pend_q, abort_pend_d;
  logic        txn_ack_q, txn_ack_d;

  logic [2:0]  cfg_eff;
  logic [10:0] mp_cfg, mp_dw, bound_dw, calc_len;
  logic [31:0] min_t;

  // Low address/length bits are dword-alignment padding and are never used.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.SG_ELEM_ADDR[1:0], bus.SG_ELEM_LEN[1:0], C_DATA_WIDTH[0]};

  // Request length: smallest of transaction remainder, element remainder, payload limit, distance to 4KB
  always_comb begin
    cfg_eff  = (CONFIG_MAX_PAYLOAD_SIZE > 3'd5) ? 3'd5 : CONFIG_MAX_PAYLOAD_SIZE;
    mp_cfg   = 11'd32 << cfg_eff;
    mp_dw    = (mp_cfg < MP_CLAMP) ? mp_cfg : MP_CLAMP;
    bound_dw = 11'd1024 - {1'b0, elem_addr_q[11:2]};
    min_t    = remain_q;
    if ({2'b0, elem_remain_q} < min_t) min_t = {2'b0, elem_remain_q};
    if ({21'b0, mp_dw} < min_t)        min_t = {21'b0, mp_dw};
    if ({21'b0, bound_dw} < min_t)     min_t = {21'b0, bound_dw};
    calc_len = min_t[10:0];
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      remain_q      <= '0;
      sent_q        <= '0;
      elem_addr_q   <= '0;
      elem_remain_q <= '0;
      req_len_q     <= '0;
      abort_pend_q  <= 1'b0;
      txn_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      sent_q        <= sent_d;
      elem_addr_q   <= elem_addr_d;
      elem_remain_q <= elem_remain_d;
      req_len_q     <= req_len_d;
      abort_pend_q  <= abort_pend_d;
      txn_ack_q     <= txn_ack_d;
    end
  end

  // Next-state logic; ABORT beats a pending SG pop but loses to a same-cycle request ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (TXN) state_d = (TXN_LEN == 32'd0) ? S_DONE : S_WAIT_SG;
      S_WAIT_SG: begin
        if (ABORT) state_d = S_DONE;
        else if (bus.SG_ELEM_RDY && (bus.SG_ELEM_LEN[31:2] != 30'd0)) state_d = S_CALC;
      end
      S_CALC:      state_d = ABORT ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.WR_REQ_ACK) state_d = S_WAIT_SENT;
        else if (ABORT)     state_d = S_DONE;
      end
      S_WAIT_SENT: begin
        if (bus.WR_SENT) begin
          if ((remain_q == 32'd0) || abort_pend_q || ABORT) state_d = S_DONE;
          else if (elem_remain_q == 30'd0)                   state_d = S_WAIT_SG;
          else                                               state_d = S_CALC;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch transaction, latch element, size request, account on ack
  always_comb begin
    remain_d      = remain_q;
    sent_d        = sent_q;
    elem_addr_d   = elem_addr_q;
    elem_remain_d = elem_remain_q;
    req_len_d     = req_len_q;
    abort_pend_d  = abort_pend_q;
    txn_ack_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TXN) begin
          remain_d     = TXN_LEN;
          sent_d       = '0;
          txn_ack_d    = 1'b1;
          abort_pend_d = 1'b0;
        end
      end
      S_WAIT_SG: begin
        if (!ABORT && bus.SG_ELEM_RDY) begin
          elem_addr_d   = {bus.SG_ELEM_ADDR[63:2], 2'b00};
          elem_remain_d = bus.SG_ELEM_LEN[31:2];
        end
      end
      S_CALC:      req_len_d = calc_len;
      S_REQ: begin
        if (bus.WR_REQ_ACK) begin
          elem_addr_d   = elem_addr_q + {51'b0, req_len_q, 2'b00};
          elem_remain_d = elem_remain_q - {19'b0, req_len_q};
          remain_d      = remain_q - {21'b0, req_len_q};
          sent_d        = sent_q + {21'b0, req_len_q};
        end
      end
      S_WAIT_SENT: abort_pend_d = abort_pend_q | ABORT;
      S_DONE:      abort_pend_d = 1'b0;
      default:     abort_pend_d = 1'b0;
    endcase
  end

  // Outputs decoded from state; request fields forced to 0 outside REQ
  always_comb begin
    TXN_ACK         = txn_ack_q;
    bus.SG_ELEM_REN = (state_q == S_WAIT_SG) && bus.SG_ELEM_RDY && !ABORT;
    bus.WR_REQ      = (state_q == S_REQ);
    bus.WR_ADDR     = (state_q == S_REQ) ? elem_addr_q : 64'd0;
    bus.WR_LEN      = (state_q == S_REQ) ? req_len_q[9:0] : 10'd0;
    bus.WR_LAST     = (state_q == S_REQ) && ({21'b0, req_len_q} == remain_q);
    DONE            = (state_q == S_DONE);
    DONE_LEN        = (state_q == S_DONE) ? sent_q : 32'd0;
  end

endmodule

// File: tb/tb_tx_write_requester_64.sv
// tb/tb_tx_write_requester_64.sv - directed bench for tx_write_requester_64
module tb_tx_write_requester_64;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  cfg = 3'd0;
  logic        TXN = 1'b0;
  logic [31:0] TXN_LEN = '0;
  logic        TXN_ACK;
  logic        ABORT = 1'b0;
  logic        DONE;
  logic [31:0] DONE_LEN;

  int n_cmp = 0;
  int n_fail = 0;
  int ren_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_done_len = '0;
  logic wr_prev = 1'b0;

  tx_write_requester_64_if bus ();

  tx_write_requester_64 #(.C_DATA_WIDTH(64), .C_MAX_PAYLOAD_DW(256)) dut (
    .CLK(CLK), .RST(RST), .CONFIG_MAX_PAYLOAD_SIZE(cfg), .TXN(TXN), .TXN_LEN(TXN_LEN),
    .TXN_ACK(TXN_ACK), .ABORT(ABORT), .DONE(DONE), .DONE_LEN(DONE_LEN), .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.SG_ELEM_REN === 1'b1) ren_cnt++;
    if ((bus.WR_REQ === 1'b1) && (wr_prev !== 1'b1)) wr_cnt++;
    wr_prev = bus.WR_REQ;
    if (DONE === 1'b1) begin
      done_cnt++;
      last_done_len = DONE_LEN;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_txn(input logic [31:0] len, output logic ack);
    TXN = 1'b1;
    TXN_LEN = len;
    tick();
    TXN = 1'b0;
    TXN_LEN = '0;
    @(negedge CLK);
    ack = TXN_ACK;
    tick();
  endtask

  task automatic feed_sg(input logic [63:0] a, input logic [31:0] l, output logic ok);
    ok = 1'b0;
    bus.SG_ELEM_ADDR = a;
    bus.SG_ELEM_LEN = l;
    bus.SG_ELEM_RDY = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.SG_ELEM_REN === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus.SG_ELEM_RDY = 1'b0;
  endtask

  task automatic wait_req(output logic [63:0] a, output logic [9:0] l, output logic last, output logic ok);
    ok = 1'b0; a = '0; l = '0; last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.WR_REQ === 1'b1) begin
        ok = 1'b1; a = bus.WR_ADDR; l = bus.WR_LEN; last = bus.WR_LAST;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic ack_req();
    bus.WR_REQ_ACK = 1'b1;
    tick();
    bus.WR_REQ_ACK = 1'b0;
  endtask

  task automatic pulse_sent();
    bus.WR_SENT = 1'b1;
    tick();
    bus.WR_SENT = 1'b0;
  endtask

  task automatic wait_done(input int base, output logic ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
      #1;
      cyc++;
    end
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    n_cmp++;
    if ({TXN_ACK, bus.SG_ELEM_REN, bus.WR_REQ, bus.WR_LAST, DONE} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {TXN_ACK, bus.SG_ELEM_REN, bus.WR_REQ, bus.WR_LAST, DONE});
    end
    n_cmp++;
    if ({bus.WR_ADDR, bus.WR_LEN} !== 74'd0) begin
      n_fail++; $display("FAIL reset_wr_bus: got %h/%h expected 0/0", bus.WR_ADDR, bus.WR_LEN);
    end
    n_cmp++;
    if (DONE_LEN !== 32'd0) begin
      n_fail++; $display("FAIL reset_done_len: got %h expected 0", DONE_LEN);
    end
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_split();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base;
    cfg = 3'd0; base = done_cnt;
    start_txn(32'd64, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL t1_txn_ack: got %b expected 1", ack); end
    feed_sg(64'h1000, 32'd1024, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t1_sg_pop: got %b expected 1", ok); end
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h1000, 10'd32, 1'b0}) begin
      n_fail++; $display("FAIL t1_req0: got ok=%b %h/%0d/%b expected ok=1 1000/32/0", ok, a, l, last); end
    TXN = 1'b1; TXN_LEN = 32'd5;
    ack_req();
    TXN = 1'b0; TXN_LEN = '0;
    @(negedge CLK);
    n_cmp++; if (TXN_ACK !== 1'b0) begin n_fail++; $display("FAIL t1_txn_ignored: got %b expected 0", TXN_ACK); end
    tick();
    pulse_sent();
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h1080, 10'd32, 1'b1}) begin
      n_fail++; $display("FAIL t1_req1: got ok=%b %h/%0d/%b expected ok=1 1080/32/1", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd64}) begin
      n_fail++; $display("FAIL t1_done: got ok=%b len=%0d expected ok=1 len=64", ok, last_done_len); end
    repeat (3) tick();
    n_cmp++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL t1_done_pulse: got %0d expected %0d", done_cnt, base + 1); end
  endtask

  task automatic test_boundary();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base;
    cfg = 3'd1; base = done_cnt;
    start_txn(32'd40, ack);
    feed_sg(64'h0FF0, 32'd4096, ok);
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h0FF0, 10'd4, 1'b0}) begin
      n_fail++; $display("FAIL t2_req0: got ok=%b %h/%0d/%b expected ok=1 ff0/4/0", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h1000, 10'd36, 1'b1}) begin
      n_fail++; $display("FAIL t2_req1: got ok=%b %h/%0d/%b expected ok=1 1000/36/1", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd40}) begin
      n_fail++; $display("FAIL t2_done: got ok=%b len=%0d expected ok=1 len=40", ok, last_done_len); end
  endtask

  task automatic test_elements();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base, ren0, wr0;
    cfg = 3'd0; base = done_cnt; ren0 = ren_cnt; wr0 = wr_cnt;
    start_txn(32'd32, ack);
    feed_sg(64'hA000, 32'd64, ok);
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'hA000, 10'd16, 1'b0}) begin
      n_fail++; $display("FAIL t3_req0: got ok=%b %h/%0d/%b expected ok=1 a000/16/0", ok, a, l, last); end
    ack_req(); pulse_sent();
    feed_sg(64'hB000, 32'd64, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t3_second_pop: got %b expected 1", ok); end
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'hB000, 10'd16, 1'b1}) begin
      n_fail++; $display("FAIL t3_req1: got ok=%b %h/%0d/%b expected ok=1 b000/16/1", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd32}) begin
      n_fail++; $display("FAIL t3_done: got ok=%b len=%0d expected ok=1 len=32", ok, last_done_len); end
    n_cmp++; if ({ren_cnt - ren0, wr_cnt - wr0} !== {32'd2, 32'd2}) begin
      n_fail++; $display("FAIL t3_counts: got ren=%0d wr=%0d expected ren=2 wr=2", ren_cnt - ren0, wr_cnt - wr0); end
  endtask

  task automatic test_clamp_stall();
    logic ack, ok, last; logic [63:0] a, ea; logic [9:0] l; int cyc; int base;
    cfg = 3'd5; base = done_cnt;
    start_txn(32'd1024, ack);
    feed_sg(64'h2000, 32'd8192, ok);
    for (int k = 0; k < 4; k++) begin
      ea = 64'h2000 + 64'(k) * 64'h400;
      wait_req(a, l, last, ok);
      n_cmp++; if ({ok, a, l, last} !== {1'b1, ea, 10'd256, (k == 3)}) begin
        n_fail++; $display("FAIL t4_req%0d: got ok=%b %h/%0d/%b expected %h/256/%b", k, ok, a, l, last, ea, (k == 3)); end
      for (int s = 0; s < 5; s++) begin
        @(negedge CLK);
        n_cmp++; if ({bus.WR_REQ, bus.WR_ADDR, bus.WR_LEN, bus.WR_LAST} !== {1'b1, ea, 10'd256, (k == 3)}) begin
          n_fail++; $display("FAIL t4_stable%0d_%0d: got %b/%h/%0d/%b expected 1/%h/256/%b", k, s, bus.WR_REQ, bus.WR_ADDR, bus.WR_LEN, bus.WR_LAST, ea, (k == 3)); end
        tick();
      end
      ack_req();
      @(negedge CLK);
      n_cmp++; if (bus.WR_REQ !== 1'b0) begin n_fail++; $display("FAIL t4_drop%0d: got %b expected 0", k, bus.WR_REQ); end
      tick();
      pulse_sent();
    end
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd1024}) begin
      n_fail++; $display("FAIL t4_done: got ok=%b len=%0d expected ok=1 len=1024", ok, last_done_len); end
  endtask

  task automatic test_abort_wait_sg();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base, wr0;
    cfg = 3'd0; base = done_cnt; wr0 = wr_cnt;
    start_txn(32'd32, ack);
    feed_sg(64'hA000, 32'd64, ok);
    wait_req(a, l, last, ok);
    ack_req(); pulse_sent();
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd16}) begin
      n_fail++; $display("FAIL t5_done: got ok=%b len=%0d expected ok=1 len=16", ok, last_done_len); end
    repeat (5) tick();
    n_cmp++; if (wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL t5_no_more_req: got %0d expected 1", wr_cnt - wr0); end
  endtask

  task automatic test_abort_req();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base;
    cfg = 3'd0; base = done_cnt;
    start_txn(32'd32, ack);
    feed_sg(64'h3000, 32'd256, ok);
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h3000, 10'd32, 1'b1}) begin
      n_fail++; $display("FAIL ab_req: got ok=%b %h/%0d/%b expected ok=1 3000/32/1", ok, a, l, last); end
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    @(negedge CLK);
    n_cmp++; if (bus.WR_REQ !== 1'b0) begin n_fail++; $display("FAIL ab_req_drop: got %b expected 0", bus.WR_REQ); end
    tick();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL ab_req_done: got ok=%b len=%0d expected ok=1 len=0", ok, last_done_len); end
  endtask

  task automatic test_abort_wait_sent();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base;
    cfg = 3'd0; base = done_cnt;
    start_txn(32'd64, ack);
    feed_sg(64'h4000, 32'd1024, ok);
    wait_req(a, l, last, ok);
    ack_req();
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    repeat (2) tick();
    n_cmp++; if (done_cnt !== base) begin n_fail++; $display("FAIL ws_early_done: got %0d expected %0d", done_cnt, base); end
    pulse_sent();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd32}) begin
      n_fail++; $display("FAIL ws_done: got ok=%b len=%0d expected ok=1 len=32", ok, last_done_len); end
  endtask

  task automatic test_zero_len();
    logic ack, ok; int cyc; int base, ren0, wr0;
    base = done_cnt; ren0 = ren_cnt; wr0 = wr_cnt;
    start_txn(32'd0, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL t6_zero_ack: got %b expected 1", ack); end
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd0} || cyc > 3) begin
      n_fail++; $display("FAIL t6_zero_done: got ok=%b len=%0d cyc=%0d expected ok=1 len=0 cyc<=3", ok, last_done_len, cyc); end
    n_cmp++; if ({ren_cnt - ren0, wr_cnt - wr0} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL t6_zero_idle: got ren=%0d wr=%0d expected 0/0", ren_cnt - ren0, wr_cnt - wr0); end
  endtask

  task automatic test_carry();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int cyc; int base;
    cfg = 3'd0; base = done_cnt;
    start_txn(32'd64, ack);
    feed_sg(64'hFFFF_FF80, 32'd1024, ok);
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'hFFFF_FF80, 10'd32, 1'b0}) begin
      n_fail++; $display("FAIL t6_carry_req0: got ok=%b %h/%0d/%b expected ok=1 ffffff80/32/0", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_req(a, l, last, ok);
    n_cmp++; if ({ok, a, l, last} !== {1'b1, 64'h1_0000_0000, 10'd32, 1'b1}) begin
      n_fail++; $display("FAIL t6_carry_req1: got ok=%b %h/%0d/%b expected ok=1 100000000/32/1", ok, a, l, last); end
    ack_req(); pulse_sent();
    wait_done(base, ok, cyc);
    n_cmp++; if ({ok, last_done_len} !== {1'b1, 32'd64}) begin
      n_fail++; $display("FAIL t6_carry_done: got ok=%b len=%0d expected ok=1 len=64", ok, last_done_len); end
  endtask

  task automatic test_rst_mid();
    logic ack, ok, last; logic [63:0] a; logic [9:0] l; int base;
    cfg = 3'd0; base = done_cnt;
    start_txn(32'd64, ack);
    feed_sg(64'h5000, 32'd1024, ok);
    wait_req(a, l, last, ok);
    RST = 1'b1; tick();
    @(negedge CLK);
    n_cmp++; if (bus.WR_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", bus.WR_REQ); end
    tick(); RST = 1'b0;
    repeat (4) tick();
    n_cmp++; if (done_cnt !== base) begin n_fail++; $display("FAIL rst_mid_done: got %0d expected %0d", done_cnt, base); end
  endtask

  initial begin
    bus.SG_ELEM_RDY = 1'b0;
    bus.SG_ELEM_ADDR = '0;
    bus.SG_ELEM_LEN = '0;
    bus.WR_REQ_ACK = 1'b0;
    bus.WR_SENT = 1'b0;
    test_reset();
    test_split();
    test_boundary();
    test_elements();
    test_clamp_stall();
    test_abort_wait_sg();
    test_abort_req();
    test_abort_wait_sent();
    test_zero_len();
    test_carry();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
